// File: rtl/sl_rx_scheduler.sv
// ---------------------------------------------------------------------------
// sl_rx_scheduler
//   Round-robin drain of CHANNEL_COUNT SL receivers into the host-bound 34-bit
//   FIFO write port. Each transfer is framed with 2-bit modifiers:
//     CHANNEL (2'd3) word when the source channel changes, payload {ch,1'b1}
//     DATA    (2'd1) word carrying the received 32-bit word
//     STATUS  (2'd2) word carrying the receiver status (optional)
//
//   Optional feature macro: RX_STATUS_APPEND_EN
//     defined   -> every DATA word is followed by a STATUS word
//     undefined -> no STATUS words; rd_status_rx is ignored
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = new grants allowed
//   data_ready_rx       per-receiver word-available level flags
//   rd_data_rx          received words, channel i at [32i+31:32i]
//   rd_status_rx        receiver status, RX_STATUS_REG_WIDTH bits per channel
//   word_picked_rx      one-cycle pulse on the channel whose word was written
//   fifo_write_full     FIFO cannot accept a word
//   fifo_write_data     {modifier[1:0], payload[31:0]}, held until next write
//   fifo_write_inc      one-cycle write strobe
//   cur_channel         index of the currently granted channel
//   busy                FSM not in IDLE
//   clr_timeout_err     sticky: granted receiver kept its ready flag too long
// ---------------------------------------------------------------------------
module sl_rx_scheduler #(
  parameter int CHANNEL_COUNT       = 2,
  parameter int RX_STATUS_REG_WIDTH = 16,
  parameter int CLR_TIMEOUT         = 15
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       enable,
  input  logic [CHANNEL_COUNT-1:0]                   data_ready_rx,
  input  logic [32*CHANNEL_COUNT-1:0]                rd_data_rx,
  input  logic [RX_STATUS_REG_WIDTH*CHANNEL_COUNT-1:0] rd_status_rx,
  output logic [CHANNEL_COUNT-1:0]                   word_picked_rx,
  input  logic                                       fifo_write_full,
  output logic [33:0]                                fifo_write_data,
  output logic                                       fifo_write_inc,
  output logic [3:0]                                 cur_channel,
  output logic                                       busy,
  output logic                                       clr_timeout_err
);

  localparam int GW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

  localparam logic [1:0] MOD_DATA    = 2'd1;
  localparam logic [1:0] MOD_STATUS  = 2'd2;
  localparam logic [1:0] MOD_CHANNEL = 2'd3;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GRANT     = 3'd1;
  localparam logic [2:0] SEND_CH   = 3'd2;
  localparam logic [2:0] SEND_DATA = 3'd3;
`ifdef RX_STATUS_APPEND_EN
  localparam logic [2:0] SEND_STAT = 3'd4;
`endif
  localparam logic [2:0] WAIT_CLR  = 3'd5;

  logic [2:0]               r_state;
  logic [GW-1:0]            r_sel;
  logic [GW-1:0]            r_last_grant;
  logic [GW-1:0]            r_last_ch;
  logic                     r_ch_valid;
  logic [7:0]               r_cnt;
  logic [33:0]              r_wdata;
  logic                     r_inc;
  logic [CHANNEL_COUNT-1:0] r_picked;
  logic [3:0]               r_cur_channel;
  logic                     r_busy;
  logic                     r_err;

  logic [2:0]               w_next;
  logic                     w_can_write;
  logic                     w_tmo;
  logic                     w_rr_found;
  logic [GW-1:0]            w_rr_grant;
  logic [31:0]              w_rx_data [CHANNEL_COUNT];

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_unpack_data
    assign w_rx_data[g] = rd_data_rx[32*g +: 32];
  end

`ifdef RX_STATUS_APPEND_EN
  logic [RX_STATUS_REG_WIDTH-1:0] w_rx_stat [CHANNEL_COUNT];
  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_unpack_stat
    assign w_rx_stat[g] = rd_status_rx[RX_STATUS_REG_WIDTH*g +: RX_STATUS_REG_WIDTH];
  end
`else
  // Status port is kept for pin compatibility but carries no function here.
  logic w_unused_status;
  assign w_unused_status = ^rd_status_rx;
`endif

  // A write may only follow a cycle without a strobe, so writes never touch.
  assign w_can_write = !fifo_write_full && !r_inc;
  // Counter starts at 0 in the first WAIT_CLR cycle; this fires on the
  // CLR_TIMEOUT-th edge spent waiting.
  assign w_tmo       = (r_cnt == 8'(CLR_TIMEOUT - 1));

  // Round-robin search starting one past the previous grant, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_grant = '0;
    for (int i = 1; i <= CHANNEL_COUNT; i++) begin
      int idx;
      idx = int'(r_last_grant) + i;
      if (idx >= CHANNEL_COUNT) idx = idx - CHANNEL_COUNT;
      if (!w_rr_found && data_ready_rx[idx[GW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_grant = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (enable && (|data_ready_rx)) w_next = GRANT;
      // Requests may vanish between IDLE and GRANT; fall back if so.
      GRANT: begin
        if (!w_rr_found)                                  w_next = IDLE;
        else if (!r_ch_valid || (w_rr_grant != r_last_ch)) w_next = SEND_CH;
        else                                              w_next = SEND_DATA;
      end
      SEND_CH:   if (w_can_write) w_next = SEND_DATA;
`ifdef RX_STATUS_APPEND_EN
      SEND_DATA: if (w_can_write) w_next = SEND_STAT;
      SEND_STAT: if (w_can_write) w_next = WAIT_CLR;
`else
      SEND_DATA: if (w_can_write) w_next = WAIT_CLR;
`endif
      WAIT_CLR:  if (!data_ready_rx[r_sel] || w_tmo) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_sel         <= '0;
      r_last_grant  <= GW'(CHANNEL_COUNT - 1);
      r_last_ch     <= '0;
      r_ch_valid    <= 1'b0;
      r_cnt         <= '0;
      r_wdata       <= '0;
      r_inc         <= 1'b0;
      r_picked      <= '0;
      r_cur_channel <= '0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != IDLE);
      r_inc    <= 1'b0;
      r_picked <= '0;
      case (r_state)
        GRANT: begin
          if (w_rr_found) begin
            r_sel         <= w_rr_grant;
            r_last_grant  <= w_rr_grant;
            r_cur_channel <= 4'(w_rr_grant);
          end
        end
        SEND_CH: begin
          if (w_can_write) begin
            r_inc      <= 1'b1;
            r_wdata    <= {MOD_CHANNEL, 32'({r_sel, 1'b1})};
            r_last_ch  <= r_sel;
            r_ch_valid <= 1'b1;
          end
        end
        // Data is taken at issue time, so stalls see the newest word.
        SEND_DATA: begin
          if (w_can_write) begin
            r_inc    <= 1'b1;
            r_wdata  <= {MOD_DATA, w_rx_data[r_sel]};
            r_picked <= CHANNEL_COUNT'(1) << r_sel;
            r_cnt    <= '0;
          end
        end
`ifdef RX_STATUS_APPEND_EN
        SEND_STAT: begin
          if (w_can_write) begin
            r_inc   <= 1'b1;
            r_wdata <= {MOD_STATUS, 32'(w_rx_stat[r_sel])};
            r_cnt   <= '0;
          end
        end
`endif
        WAIT_CLR: begin
          r_cnt <= r_cnt + 8'd1;
          if (data_ready_rx[r_sel] && w_tmo) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_write_data = r_wdata;
  assign fifo_write_inc  = r_inc;
  assign word_picked_rx  = r_picked;
  assign cur_channel     = r_cur_channel;
  assign busy            = r_busy;
  assign clr_timeout_err = r_err;

endmodule

// File: tb/tb_sl_rx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sl_rx_scheduler
//   Scoreboard bench: expected FIFO words are queued when stimulus is applied
//   and compared as strobes appear. A simple receiver model drops a channel's
//   ready flag the cycle after its pick pulse (unless disabled).
// ---------------------------------------------------------------------------
module tb_sl_rx_scheduler;

  localparam int CC  = 2;
  localparam int SW  = 16;
  localparam int TMO = 15;
  localparam int GW  = (CC > 1) ? $clog2(CC) : 1;

  typedef logic [GW-1:0] ch_t;
  typedef struct packed {
    logic [33:0]   word;
    logic [CC-1:0] pick;
    logic [3:0]    ch;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [CC-1:0]     data_ready_rx;
  wire  [32*CC-1:0]  rd_data_rx;
  wire  [SW*CC-1:0]  rd_status_rx;
  logic [CC-1:0]     word_picked_rx;
  logic              fifo_write_full;
  logic [33:0]       fifo_write_data;
  logic              fifo_write_inc;
  logic [3:0]        cur_channel;
  logic              busy;
  logic              clr_timeout_err;

  logic [31:0]       tb_data [CC];
  logic [SW-1:0]     tb_stat [CC];

  for (genvar g = 0; g < CC; g++) begin : g_pack
    assign rd_data_rx[32*g +: 32]   = tb_data[g];
    assign rd_status_rx[SW*g +: SW] = tb_stat[g];
  end

  sl_rx_scheduler #(
    .CHANNEL_COUNT(CC), .RX_STATUS_REG_WIDTH(SW), .CLR_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .data_ready_rx(data_ready_rx), .rd_data_rx(rd_data_rx),
    .rd_status_rx(rd_status_rx), .word_picked_rx(word_picked_rx),
    .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data),
    .fifo_write_inc(fifo_write_inc), .cur_channel(cur_channel),
    .busy(busy), .clr_timeout_err(clr_timeout_err)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   strobe_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_strobes = 0;
  logic prev_inc = 1'b0;
  bit   auto_clr = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic push_raw(input logic [33:0] w, input logic [CC-1:0] p, input logic [3:0] c);
    exp_t e;
    e.word = w; e.pick = p; e.ch = c;
    sb.push_back(e);
  endtask

  task automatic exp_ch(input ch_t ch);
    push_raw({2'd3, 32'(2 * int'(ch) + 1)}, '0, 4'(ch));
  endtask

  task automatic exp_data(input ch_t ch, input logic [31:0] d);
    push_raw({2'd1, d}, CC'(1) << ch, 4'(ch));
`ifdef RX_STATUS_APPEND_EN
    push_raw({2'd2, 32'(tb_stat[ch])}, '0, 4'(ch));
`endif
  endtask

  task automatic monitor();
    exp_t e;
    if (fifo_write_inc) begin
      chk("no_back_to_back", prev_inc, 0);
      strobe_cyc.push_back(cyc);
      n_strobes++;
      if (sb.size() == 0) chk("unexpected_write", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("fifo_word", fifo_write_data, e.word);
        chk("picked", word_picked_rx, e.pick);
        chk("cur_channel", cur_channel, e.ch);
      end
    end else if (word_picked_rx != '0) begin
      chk("stray_pick", word_picked_rx, 0);
    end
    if (auto_clr) data_ready_rx = data_ready_rx & ~word_picked_rx;
    prev_inc = fifo_write_inc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_idle"}, busy, 0);
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, fifo_write_data, 0);
    chk({tag, "_inc"}, fifo_write_inc, 0);
    chk({tag, "_pick"}, word_picked_rx, 0);
    chk({tag, "_chan"}, cur_channel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, clr_timeout_err, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk_zero(tag);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    prev_inc = 1'b0;
  endtask

  initial begin
    int n;
    int s0;
    int cyc0;
    rst_n = 1'b0;
    enable = 1'b1;
    data_ready_rx = '0;
    fifo_write_full = 1'b0;
    for (int i = 0; i < CC; i++) begin
      tb_data[i] = '0;
      tb_stat[i] = '0;
    end
    #12;
    chk_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Test 1: first transfer after reset needs a CHANNEL word.
    strobe_cyc.delete();
    tb_data[0] = 32'hDEADBEEF;
    tb_stat[0] = 16'h0005;
    push_raw(34'h3_0000_0001, 2'b00, 4'd0);
    exp_data(0, 32'hDEADBEEF);
    data_ready_rx[0] = 1'b1;
    wait_idle("t1");
    chk("t1_gap", strobe_cyc[1] - strobe_cyc[0], 2);

    // Test 2: simultaneous requests served ch0 then ch1.
    do_reset("t2_reset");
    tb_data[0] = 32'hA0A0_0000;
    tb_data[1] = 32'hA1A1_1111;
    tb_stat[1] = 16'h00A1;
    push_raw(34'h3_0000_0001, 2'b00, 4'd0);
    exp_data(0, 32'hA0A0_0000);
    push_raw(34'h3_0000_0003, 2'b00, 4'd1);
    exp_data(1, 32'hA1A1_1111);
    data_ready_rx = 2'b11;
    wait_idle("t2");

    // Test 3: same channel again -> DATA only, 3-cycle latency.
    strobe_cyc.delete();
    tb_data[1] = 32'hB1B1_0001;
    exp_data(1, 32'hB1B1_0001);
    cyc0 = cyc;
    data_ready_rx[1] = 1'b1;
    wait_idle("t3a");
    chk("t3_latency", strobe_cyc[0] - cyc0, 3);
    tb_data[1] = 32'hB1B1_0002;
    exp_data(1, 32'hB1B1_0002);
    data_ready_rx[1] = 1'b1;
    wait_idle("t3b");

    // Test 4: FIFO full for 10 cycles while in SEND_DATA.
    tb_data[0] = 32'hC0C0_0000;
    push_raw(34'h3_0000_0001, 2'b00, 4'd0);
    data_ready_rx[0] = 1'b1;
    s0 = n_strobes;
    n = 0;
    while (n_strobes == s0 && n < 20) begin
      step();
      n++;
    end
    chk("t4_ch_written", n_strobes - s0, 1);
    fifo_write_full = 1'b1;
    tb_data[0] = 32'hC0C0_0001;
    exp_data(0, 32'hC0C0_0001);
    s0 = n_strobes;
    repeat (10) step();
    chk("t4_stall_no_write", n_strobes - s0, 0);
    fifo_write_full = 1'b0;
    step();
    chk("t4_release", n_strobes - s0, 1);
    wait_idle("t4");

    // Enable low blocks new grants; dropping it mid-sequence lets it finish.
    enable = 1'b0;
    tb_data[1] = 32'hE1E1_0000;
    data_ready_rx[1] = 1'b1;
    repeat (5) step();
    chk("en_off_busy", busy, 0);
    exp_ch(1);
    exp_data(1, 32'hE1E1_0000);
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    wait_idle("en_mid");
    enable = 1'b1;

    // Test 5: ready never clears -> timeout, then a new sequence.
    auto_clr = 1'b0;
    tb_data[0] = 32'hF0F0_0000;
    exp_ch(0);
    exp_data(0, 32'hF0F0_0000);
    data_ready_rx[0] = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("t5_sent", sb.size(), 0);
    chk("t5_err_before", clr_timeout_err, 0);
    n = 0;
    while (!clr_timeout_err && n < 40) begin
      step();
      n++;
    end
    chk("t5_tmo_cycles", n, TMO);
    auto_clr = 1'b1;
    tb_data[0] = 32'hF0F0_0001;
    exp_data(0, 32'hF0F0_0001);
    wait_idle("t5_next");
    chk("t5_err_sticky", clr_timeout_err, 1);

`ifdef RX_STATUS_APPEND_EN
    // Test 6: reset while the STATUS word is pending.
    do_reset("t6_reset0");
    tb_data[0] = 32'h6060_0000;
    tb_stat[0] = 16'h0005;
    push_raw(34'h3_0000_0001, 2'b00, 4'd0);
    push_raw({2'd1, 32'h6060_0000}, 2'b01, 4'd0);
    push_raw(34'h2_0000_0005, 2'b00, 4'd0);
    data_ready_rx[0] = 1'b1;
    n = 0;
    while (sb.size() > 1 && n < 40) begin
      step();
      n++;
    end
    chk("t6_data_sent", sb.size(), 1);
    do_reset("t6_reset_mid");
    tb_data[0] = 32'h6060_0001;
    exp_ch(0);
    exp_data(0, 32'h6060_0001);
    data_ready_rx[0] = 1'b1;
    wait_idle("t6");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sl_rx_scheduler.md
Name: sl_rx_scheduler

Overview:
Round-robin scheduler that drains received words from CHANNEL_COUNT SL receivers into the host-bound 34-bit FIFO write port, so the host does not have to poll each channel.
Each transfer is framed in the existing modifier format: a CHANNEL word when the source channel changes, then a DATA word, then an optional STATUS word.
It sits between the receiver array and the outgoing FIFO, in parallel with the command/readback commutator. The host-link mux in front of the FIFO is outside this block.

Parameters:
CHANNEL_COUNT, 2, number of receivers (2..16)
RX_STATUS_REG_WIDTH, 16, width of each receiver status register
CLR_TIMEOUT, 15, cycles to wait for the picked receiver to drop its ready flag (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = scheduling allowed
data_ready_rx  in  CHANNEL_COUNT  per-receiver "word available" flag, level
rd_data_rx  in  32*CHANNEL_COUNT  received words; channel i at [32i+31:32i]
rd_status_rx  in  RX_STATUS_REG_WIDTH*CHANNEL_COUNT  receiver status, packed the same way
word_picked_rx  out  CHANNEL_COUNT  one-cycle pulse, word consumed
fifo_write_full  in  1  FIFO cannot accept a word
fifo_write_data  out  34  {modifier[1:0], payload[31:0]}
fifo_write_inc  out  1  one-cycle write strobe
cur_channel  out  4  granted channel index
busy  out  1  FSM not in IDLE
clr_timeout_err  out  1  sticky; set on ready-clear timeout

Behaviour:
- Reset (async) values: all outputs 0. Internal state: last_grant=CHANNEL_COUNT-1 (channel 0 wins first), ch_valid=0, FSM=IDLE.
- Modifiers: DATA=2'd1, STATUS=2'd2, CHANNEL=2'd3. Channel payload = {ch, 1'b1} zero-extended to 32 bits; bit0=1 marks a receiver. Status payload is zero-extended.
- All outputs are registered. fifo_write_data is valid in the same cycle fifo_write_inc=1 and holds its value until the next write.
- Write rule: a word is issued at an edge only if fifo_write_full=0 at that edge and fifo_write_inc is currently 0. Writes are therefore never back-to-back; minimum spacing is 2 cycles.
- FSM states and transitions:
  IDLE: if enable and |data_ready_rx, move to GRANT.
  GRANT: grant = first set bit searching from last_grant+1, wrapping modulo CHANNEL_COUNT. Update last_grant and cur_channel. If !ch_valid or grant != last_ch, go to SEND_CH; else go to SEND_DATA. Costs 1 cycle.
  SEND_CH: issue the CHANNEL word, set last_ch=grant and ch_valid=1, go to SEND_DATA.
  SEND_DATA: issue {DATA, rd_data_rx[grant]} and pulse word_picked_rx[grant] in the same cycle as the strobe. Go to SEND_STAT if the feature is enabled, else to WAIT_CLR.
  SEND_STAT: issue {STATUS, rd_status_rx[grant]}, go to WAIT_CLR.
  WAIT_CLR: counter runs from 0. If data_ready_rx[grant]=0, go to IDLE. If the counter reaches CLR_TIMEOUT, set clr_timeout_err and go to IDLE.
- Latency: ready flag to first strobe is 3 cycles when no CHANNEL word is needed (IDLE→GRANT→SEND_DATA→strobe).
- fifo_write_full held: the FSM stays in its SEND_* state with no strobe; data and ready are re-sampled at issue time.
- enable deasserted mid-sequence: the current sequence completes; no new GRANT.
- Ready of the granted channel dropping before SEND_DATA issues: the word is still sent (the rd_data value at issue time).
- Simultaneous requests are served in round-robin order; no starvation.
- busy=1 in every state except IDLE.
- clr_timeout_err clears only on reset.

Optional Feature:
RX_STATUS_APPEND_EN:
- Defined: SEND_STAT is present; every DATA word is followed by a STATUS word for the same channel.
- Undefined: SEND_STAT and the rd_status_rx logic are removed; the rd_status_rx port remains but is ignored.

Test Plan:
1. After reset, ch0 ready with rd_data=32'hDEADBEEF → writes 34'h3_0000_0001 then 34'h1_DEADBEEF; word_picked_rx=2'b01 for one cycle on the second strobe; strobes are 2 cycles apart.
2. ch0 and ch1 ready in the same cycle, each drops its ready 1 cycle after its pick → order: CH 34'h3_0000_0001, DATA ch0, CH 34'h3_0000_0003, DATA ch1.
3. ch1 ready twice in a row, no other traffic → second transfer emits DATA only, no CHANNEL word.
4. fifo_write_full=1 for 10 cycles while in SEND_DATA → no strobe during the stall; DATA written 1 cycle after full falls; no duplicate or lost word.
5. ch0 ready held high permanently, CLR_TIMEOUT=15 → clr_timeout_err set 15 cycles after entering WAIT_CLR; the next sequence then starts.
6. With RX_STATUS_APPEND_EN, status=16'h0005 → DATA word followed by 34'h2_0000_0005. Assert rst_n mid-SEND_STAT → all outputs 0; the next transfer re-emits the CHANNEL word.
